sprite_blitter: RTL and testbench

//  Writer side of the frame RAM: copies a WxH sprite of 5-bit encoded pixels from sprite ROM

---
 rtl/frame_pkg.sv | 23 ++
 rtl/blit_addr_gen.sv | 63 ++++++
 rtl/sprite_blitter.sv | 150 +++++++++++++++
 tb/tb_sprite_blitter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared screen geometry, pixel type and blitter state encoding for the frame RAM writer.
// fb_linear maps an on-screen (X, Y) pair to the linear frame RAM word address.
package frame_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int FB_AW    = 19;

    typedef logic [4:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } blit_state_t;

    // Only meaningful for on-screen coordinates; larger values simply wrap.
    function automatic logic [FB_AW-1:0] fb_linear(input logic [10:0] px, input logic [10:0] py);
        return FB_AW'(px) + FB_AW'(py) * FB_AW'(SCREEN_W);
    endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Column/row walker over the sprite rectangle: produces the row-major ROM address of the
// current pixel and flags the last pixel of the job.
module blit_addr_gen
    import frame_pkg::*;
#(
    parameter int ROM_AW = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              advance_i,
    input  logic [7:0]        w_i,
    input  logic [7:0]        h_i,
    input  logic [ROM_AW-1:0] base_i,
    output logic [7:0]        col_o,
    output logic [7:0]        row_o,
    output logic [ROM_AW-1:0] addr_o,
    output logic              last_o
);

    logic [7:0]  col_q;
    logic [7:0]  col_d;
    logic [7:0]  row_q;
    logic [7:0]  row_d;
    logic [15:0] row_off;
    logic        col_wrap;

    assign col_wrap = (col_q == w_i - 8'd1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Stride is the sprite width; the 16-bit offset and the final sum both wrap.
    assign row_off = 16'(row_q) * 16'(w_i);
    assign addr_o  = base_i + ROM_AW'(row_off) + ROM_AW'(col_q);
    assign last_o  = col_wrap && (row_q == h_i - 8'd1);
    assign col_o   = col_q;
    assign row_o   = row_q;

endmodule

// File: rtl/sprite_blitter.sv
// Copies a WxH sprite from sprite ROM into the 640x480 frame RAM during blanking,
// skipping transparent and off-screen pixels; one pixel per cycle while blank is high.
module sprite_blitter
    import frame_pkg::*;
#(
    parameter int     ROM_AW     = 16,
    parameter pixel_t TRANS_CODE = 5'h15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              blank,
    input  logic              start,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [7:0]        sprite_w,
    input  logic [7:0]        sprite_h,
    input  logic [ROM_AW-1:0] rom_base,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic              fb_we,
    output logic [18:0]       fb_addr,
    output logic [4:0]        fb_data,
    output logic              busy,
    output logic              done
);

    blit_state_t       state_q;
    logic              busy_q;
    logic              done_q;
    logic [9:0]        x_q;
    logic [9:0]        y_q;
    logic [7:0]        w_q;
    logic [7:0]        h_q;
    logic [ROM_AW-1:0] base_q;
    logic              valid_q;
    logic [7:0]        col1_q;
    logic [7:0]        row1_q;
    logic [ROM_AW-1:0] held_addr_q;

    logic              clear;
    logic              advance;
    logic [7:0]        col;
    logic [7:0]        row;
    logic [ROM_AW-1:0] gen_addr;
    logic              last;

    logic [10:0]       pix_x;
    logic [10:0]       pix_y;
    logic              on_screen;

    assign clear   = (state_q == IDLE) && start;
    assign advance = (state_q == RUN) && blank;

    blit_addr_gen #(
        .ROM_AW(ROM_AW)
    ) u_addr_gen (
        .clk_i    (Clk),
        .reset_i  (Reset),
        .clear_i  (clear),
        .advance_i(advance),
        .w_i      (w_q),
        .h_i      (h_q),
        .base_i   (base_q),
        .col_o    (col),
        .row_o    (row),
        .addr_o   (gen_addr),
        .last_o   (last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            h_q         <= '0;
            base_q      <= '0;
            valid_q     <= 1'b0;
            col1_q      <= '0;
            row1_q      <= '0;
            held_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        x_q    <= sprite_x;
                        y_q    <= sprite_y;
                        w_q    <= sprite_w;
                        h_q    <= sprite_h;
                        base_q <= rom_base;
                        busy_q <= 1'b1;
                        if (sprite_w == 8'd0 || sprite_h == 8'd0) begin
                            state_q <= FIN;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (blank) begin
                        valid_q     <= 1'b1;
                        col1_q      <= col;
                        row1_q      <= row;
                        held_addr_q <= gen_addr;
                        if (last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (blank) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    // An empty job arrives here with done still low and spends one cycle raising it.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // While frozen, re-present the in-flight pixel's address so a free-running synchronous
    // ROM keeps returning that pixel instead of running ahead.
    assign rom_addr = (valid_q && !blank) ? held_addr_q : gen_addr;

    assign pix_x     = {1'b0, x_q} + {3'b000, col1_q};
    assign pix_y     = {1'b0, y_q} + {3'b000, row1_q};
    assign on_screen = (pix_x < 11'(SCREEN_W)) && (pix_y < 11'(SCREEN_H));

    assign fb_we   = valid_q && blank && (rom_data != TRANS_CODE) && on_screen;
    assign fb_data = valid_q ? rom_data : 5'd0;
    assign fb_addr = valid_q ? fb_linear(pix_x, pix_y) : 19'd0;

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: a table of blit jobs with hand-computed write lists and
// done timing, plus stall, start-while-busy and reset-mid-job sequences.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        blank;
    logic        start;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [7:0]  sw;
    logic [7:0]  sh;
    logic [15:0] base;
    logic [15:0] rom_addr;
    logic [4:0]  rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [4:0]  fb_data;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [4:0] rom_mem [0:65535];

    always #5 clk = ~clk;

    // Synchronous sprite ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    sprite_blitter #(
        .ROM_AW    (16),
        .TRANS_CODE(5'h15)
    ) dut (
        .Clk     (clk),
        .Reset   (rst),
        .blank   (blank),
        .start   (start),
        .sprite_x(sx),
        .sprite_y(sy),
        .sprite_w(sw),
        .sprite_h(sh),
        .rom_base(base),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .fb_we   (fb_we),
        .fb_addr (fb_addr),
        .fb_data (fb_data),
        .busy    (busy),
        .done    (done)
    );

    typedef struct packed {
        logic [9:0]       x;
        logic [9:0]       y;
        logic [7:0]       w;
        logic [7:0]       h;
        logic [15:0]      base;
        logic [7:0][4:0]  rom_v;
        logic [3:0]       n_wr;
        logic [7:0][18:0] wr_addr;
        logic [7:0][4:0]  wr_data;
        logic [7:0][7:0]  wr_rel;
        logic [7:0]       done_rel;
    } job_t;

    job_t jobs [8];

    function automatic job_t mk(input int x, input int y, input int w, input int h,
                                input int b, input logic [39:0] rom, input int done_rel);
        job_t j;
        j          = '0;
        j.x        = 10'(x);
        j.y        = 10'(y);
        j.w        = 8'(w);
        j.h        = 8'(h);
        j.base     = 16'(b);
        j.rom_v    = rom;
        j.done_rel = 8'(done_rel);
        return j;
    endfunction

    function automatic job_t add_wr(input job_t j, input int addr, input int data, input int rel);
        job_t r;
        r                 = j;
        r.wr_addr[r.n_wr] = 19'(addr);
        r.wr_data[r.n_wr] = 5'(data);
        r.wr_rel[r.n_wr]  = 8'(rel);
        r.n_wr            = r.n_wr + 4'd1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // blank is low for the cycles ending at edges 3 and 4 after acceptance
    function automatic logic stall_blank(input int rel);
        return !(rel == 3 || rel == 4);
    endfunction

    // rel counts clock edges after the edge that accepted start; outputs are sampled in the
    // cycle that ends at that edge.
    task automatic run_job(input job_t j, input bit stall, input bit extra_start, input string tag);
        int  wi;
        int  ndone;
        int  lim;
        for (int i = 0; i < 8; i++) rom_mem[16'(j.base + 16'(i))] = j.rom_v[i];
        @(negedge clk);
        sx = j.x; sy = j.y; sw = j.w; sh = j.h; base = j.base;
        start = 1'b1;
        blank = 1'b1;
        @(posedge clk);
        wi    = 0;
        ndone = 0;
        lim   = int'(j.done_rel) + 4;
        $display("job %s x=%0d y=%0d w=%0d h=%0d base=%0h", tag, j.x, j.y, j.w, j.h, j.base);
        for (int rel = 1; rel <= lim; rel++) begin
            @(negedge clk);
            start = extra_start && (rel == 2);
            if (extra_start && rel == 2) begin
                sw = 8'd0;
                sx = 10'd300;
            end
            blank = stall ? stall_blank(rel) : 1'b1;
            #1;
            if (rel == 1) chk({tag, "_busy_early"}, 32'(busy), 32'd1);
            if (!blank) chk({tag, "_we_stalled"}, 32'(fb_we), 32'd0);
            if (fb_we) begin
                $display("  write %s rel=%0d addr=%0d data=%0h", tag, rel, fb_addr, fb_data);
                if (wi >= int'(j.n_wr)) begin
                    chk({tag, "_extra_write"}, 32'(wi), 32'(j.n_wr));
                end else begin
                    chk({tag, "_wr_addr"}, 32'(fb_addr), 32'(j.wr_addr[wi]));
                    chk({tag, "_wr_data"}, 32'(fb_data), 32'(j.wr_data[wi]));
                    chk({tag, "_wr_rel"}, 32'(rel), 32'(j.wr_rel[wi]));
                end
                wi++;
            end
            if (done) begin
                ndone++;
                $display("  done %s rel=%0d", tag, rel);
                chk({tag, "_done_rel"}, 32'(rel), 32'(j.done_rel));
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            end
        end
        start = 1'b0;
        blank = 1'b1;
        chk({tag, "_write_count"}, 32'(wi), 32'(j.n_wr));
        chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    endtask

    job_t jst;

    initial begin
        rst = 1'b1; blank = 1'b1; start = 1'b0;
        sx = '0; sy = '0; sw = '0; sh = '0; base = '0;

        jobs[0] = mk(0, 0, 2, 2, 'h10, {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'd2, 5'd1}, 6);
        jobs[0] = add_wr(jobs[0], 0, 1, 2);
        jobs[0] = add_wr(jobs[0], 1, 2, 3);
        jobs[0] = add_wr(jobs[0], 640, 3, 4);
        jobs[0] = add_wr(jobs[0], 641, 4, 5);

        jobs[1] = mk(0, 0, 2, 2, 'h10, {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'h15, 5'd1}, 6);
        jobs[1] = add_wr(jobs[1], 0, 1, 2);
        jobs[1] = add_wr(jobs[1], 640, 3, 4);
        jobs[1] = add_wr(jobs[1], 641, 4, 5);

        jobs[2] = mk(638, 479, 4, 2, 'h100,
                     {5'd14, 5'd13, 5'd12, 5'd11, 5'd10, 5'd9, 5'd8, 5'd7}, 10);
        jobs[2] = add_wr(jobs[2], 307198, 7, 2);
        jobs[2] = add_wr(jobs[2], 307199, 8, 3);

        jobs[3] = mk(5, 2, 3, 1, 'hFFFE, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd17, 5'd9, 5'd6}, 5);
        jobs[3] = add_wr(jobs[3], 1285, 6, 2);
        jobs[3] = add_wr(jobs[3], 1286, 9, 3);
        jobs[3] = add_wr(jobs[3], 1287, 17, 4);

        jobs[4] = mk(0, 0, 0, 3, 'h0, 40'd0, 2);
        jobs[5] = mk(0, 0, 5, 0, 'h0, 40'd0, 2);

        jobs[6] = mk(100, 10, 1, 3, 'h200, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd2, 5'd1}, 5);
        jobs[6] = add_wr(jobs[6], 6500, 1, 2);
        jobs[6] = add_wr(jobs[6], 7140, 2, 3);
        jobs[6] = add_wr(jobs[6], 7780, 3, 4);

        jobs[7] = mk(1000, 0, 2, 1, 'h300, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 5'd5}, 4);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_we", 32'(fb_we), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_fb_addr", 32'(fb_addr), 32'd0);
        chk("reset_fb_data", 32'(fb_data), 32'd0);
        $display("reset checked busy=%0d done=%0d we=%0d", busy, done, fb_we);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            run_job(jobs[k], 1'b0, 1'b0, $sformatf("vec%0d", k));
        end

        // Two frozen cycles shift the later writes and done by two.
        jst = mk(0, 0, 2, 2, 'h10, {5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd3, 5'd2, 5'd1}, 8);
        jst = add_wr(jst, 0, 1, 2);
        jst = add_wr(jst, 1, 2, 5);
        jst = add_wr(jst, 640, 3, 6);
        jst = add_wr(jst, 641, 4, 7);
        run_job(jst, 1'b1, 1'b0, "stall");

        run_job(jobs[6], 1'b0, 1'b1, "busy_start");

        // Reset during RUN abandons the job.
        @(negedge clk);
        sx = 10'd100; sy = 10'd10; sw = 8'd1; sh = 8'd3; base = 16'h200;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        $display("reset mid-job busy=%0d we=%0d done=%0d", busy, fb_we, done);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_we", 32'(fb_we), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        run_job(jobs[0], 1'b0, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
